// File: rtl/imu_burst_reader.sv
// SPI mode-0 burst reader: one read address, then NUM_REGS sensor bytes published as one word.
// Latency: data_valid 1+2H+16H*(NUM_REGS+1) clks after the accepting edge; busy ends CS_GAP clks later.
// No backpressure: triggers seen while busy are dropped and counted in overrun_cnt (saturating).
module imu_burst_reader #(
    parameter int unsigned CLK_DIV    = 6,
    parameter int unsigned NUM_REGS   = 14,
    parameter logic [7:0]  START_ADDR = 8'h3B,
    parameter int unsigned CS_GAP     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  trigger,
    output logic                  busy,
    output logic [8*NUM_REGS-1:0] data_out,
    output logic                  data_valid,
    output logic [7:0]            overrun_cnt,
    input  logic                  imu_miso,
    output logic                  imu_mosi,
    output logic                  imu_sck,
    output logic                  imu_ss
);

    localparam int unsigned HALF = 1 << (CLK_DIV - 1);
    localparam int unsigned DW   = 8 * NUM_REGS;
    localparam int unsigned BW   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned GW   = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

    localparam logic [CLK_DIV-1:0] HALF_LAST = CLK_DIV'(HALF - 1);
    localparam logic [BW-1:0]      BYTE_LAST = BW'(NUM_REGS - 1);
    localparam logic [GW-1:0]      GAP_LAST  = GW'(CS_GAP - 1);
    localparam logic [7:0]         ADDR_BYTE = {1'b1, START_ADDR[6:0]};

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ADDR,
        DATA,
        HOLD,
        GAP
    } state_t;

    state_t               state;
    logic                 start_q;
    logic [CLK_DIV-1:0]   hcnt;
    logic [2:0]           bit_idx;
    logic [BW-1:0]        byte_idx;
    logic [GW-1:0]        gcnt;
    logic [6:0]           addr_sh;
    logic [DW-1:0]        shadow;

    logic half_done;
    assign half_done = (hcnt == HALF_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            start_q     <= 1'b0;
            hcnt        <= '0;
            bit_idx     <= '0;
            byte_idx    <= '0;
            gcnt        <= '0;
            addr_sh     <= '0;
            shadow      <= '0;
            busy        <= 1'b0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            overrun_cnt <= '0;
            imu_mosi    <= 1'b0;
            imu_sck     <= 1'b0;
            imu_ss      <= 1'b1;
        end else begin
            data_valid <= 1'b0;
            start_q    <= 1'b0;

            // Accepted triggers are staged one cycle so SS and busy rise together.
            if (trigger && en) begin
                if (state == IDLE && !start_q) begin
                    start_q <= 1'b1;
                end else if (overrun_cnt != 8'hFF) begin
                    overrun_cnt <= overrun_cnt + 8'd1;
                end
            end

            case (state)
                IDLE: begin
                    if (start_q) begin
                        state    <= SETUP;
                        busy     <= 1'b1;
                        imu_ss   <= 1'b0;
                        imu_sck  <= 1'b0;
                        imu_mosi <= ADDR_BYTE[7];
                        addr_sh  <= ADDR_BYTE[6:0];
                        hcnt     <= '0;
                    end
                end

                SETUP: begin
                    if (half_done) begin
                        state   <= ADDR;
                        hcnt    <= '0;
                        bit_idx <= '0;
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end

                ADDR, DATA: begin
                    if (!half_done) begin
                        hcnt <= hcnt + 1'b1;
                    end else begin
                        hcnt <= '0;
                        if (!imu_sck) begin
                            imu_sck <= 1'b1;
                            shadow  <= {shadow[DW-2:0], imu_miso};
                        end else begin
                            // Ones shift in behind the address, giving the 0xFF dummy during DATA.
                            imu_sck  <= 1'b0;
                            imu_mosi <= addr_sh[6];
                            addr_sh  <= {addr_sh[5:0], 1'b1};
                            bit_idx  <= bit_idx + 3'd1;
                            if (bit_idx == 3'd7) begin
                                if (state == ADDR) begin
                                    state    <= DATA;
                                    byte_idx <= '0;
                                end else if (byte_idx == BYTE_LAST) begin
                                    state <= HOLD;
                                end else begin
                                    byte_idx <= byte_idx + 1'b1;
                                end
                            end
                        end
                    end
                end

                HOLD: begin
                    if (half_done) begin
                        state      <= GAP;
                        imu_ss     <= 1'b1;
                        imu_mosi   <= 1'b0;
                        data_out   <= shadow;
                        data_valid <= 1'b1;
                        gcnt       <= '0;
                        hcnt       <= '0;
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end

                GAP: begin
                    if (gcnt == GAP_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gcnt <= gcnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imu_burst_reader.sv
// Directed bench for imu_burst_reader: small instance (H=4, 2 bytes) for timing/overrun/reset,
// large instance (H=32, 14 bytes) for multi-byte data integrity.
module tb_imu_burst_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, en, trigger, en_b, trigger_b;

    logic        busy_a, dv_a, mosi_a, sck_a, ss_a, miso_a;
    logic [15:0] data_a;
    logic [7:0]  ovr_a;

    logic         busy_b, dv_b, mosi_b, sck_b, ss_b, miso_b;
    logic [111:0] data_b;
    logic [7:0]   ovr_b;

    imu_burst_reader #(.CLK_DIV(3), .NUM_REGS(2), .START_ADDR(8'h3B), .CS_GAP(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .trigger(trigger), .busy(busy_a),
        .data_out(data_a), .data_valid(dv_a), .overrun_cnt(ovr_a),
        .imu_miso(miso_a), .imu_mosi(mosi_a), .imu_sck(sck_a), .imu_ss(ss_a)
    );

    imu_burst_reader #(.CLK_DIV(6), .NUM_REGS(14), .START_ADDR(8'h3B), .CS_GAP(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .trigger(trigger_b), .busy(busy_b),
        .data_out(data_b), .data_valid(dv_b), .overrun_cnt(ovr_b),
        .imu_miso(miso_b), .imu_mosi(mosi_b), .imu_sck(sck_b), .imu_ss(ss_b)
    );

    // Slave models: rising-edge index since SS fell; bytes follow the 8 address clocks.
    logic [15:0]  slv_a = '0;
    logic [111:0] slv_b = '0;
    int rcnt_a = 0;
    int rcnt_b = 0;

    always @(negedge ss_a or posedge sck_a) begin
        if (!ss_a && sck_a) rcnt_a <= rcnt_a + 1;
        else rcnt_a <= 0;
    end
    always @(negedge ss_b or posedge sck_b) begin
        if (!ss_b && sck_b) rcnt_b <= rcnt_b + 1;
        else rcnt_b <= 0;
    end
    always_comb begin
        miso_a = 1'b0;
        if (rcnt_a >= 8 && rcnt_a < 24) miso_a = slv_a[23 - rcnt_a];
        miso_b = 1'b0;
        if (rcnt_b >= 8 && rcnt_b < 120) miso_b = slv_b[119 - rcnt_b];
    end

    // Bus monitor, sampled mid-cycle.
    logic        p_sck = 1'b0, p_mosi = 1'b0, p_ss = 1'b1;
    int          ss_run = 0, ss_last = 0, busy_run = 0, busy_last = 0;
    int          rises = 0, since = 0, per_bad = 0, mosi_bad = 0, sck_bad = 0, dv_tot = 0;
    logic [23:0] mosi_sh = '0;
    int          ss_run_b = 0, ss_last_b = 0;

    always @(negedge clk) begin
        if (ss_a && sck_a) sck_bad++;
        if (dv_a) dv_tot++;
        if (p_ss && !ss_a) begin
            rises = 0;
            since = 0;
            mosi_sh = '0;
        end
        since++;
        if (!p_sck && sck_a) begin
            if (rises > 0 && since != 8) per_bad++;
            if (mosi_a !== p_mosi) mosi_bad++;
            mosi_sh = {mosi_sh[22:0], mosi_a};
            rises++;
            since = 0;
        end
        if (!ss_a) ss_run++;
        else if (ss_run != 0) begin ss_last = ss_run; ss_run = 0; end
        if (busy_a) busy_run++;
        else if (busy_run != 0) begin busy_last = busy_run; busy_run = 0; end
        if (!ss_b) ss_run_b++;
        else if (ss_run_b != 0) begin ss_last_b = ss_run_b; ss_run_b = 0; end
        p_sck  = sck_a;
        p_mosi = mosi_a;
        p_ss   = ss_a;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_a();
        @(negedge clk) trigger = 1'b1;
        @(negedge clk) trigger = 1'b0;
    endtask

    task automatic wait_dv_a(input string tag, output int n);
        n = 0;
        while (!dv_a && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {127'd0, dv_a}, 128'd1);
    endtask

    initial begin
        int n;
        int dv0;
        int got;
        logic [127:0] rnd;

        rst_n = 1'b0; en = 1'b0; trigger = 1'b0; en_b = 1'b0; trigger_b = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ss", ss_a, 1);
        chk("rst_sck", sck_a, 0);
        chk("rst_mosi", mosi_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_dv", dv_a, 0);
        chk("rst_data", data_a, 0);
        chk("rst_ovr", ovr_a, 0);
        chk("rst_ss_b", ss_b, 1);
        rst_n = 1'b1;
        en = 1'b1;

        // Basic burst: timing, SPI shape, address byte and data.
        slv_a = 16'hA55A;
        dv0 = dv_tot;
        pulse_a();
        chk("t1_busy_k", busy_a, 0);
        chk("t1_ss_k", ss_a, 1);
        @(negedge clk);
        chk("t1_busy_k1", busy_a, 1);
        chk("t1_ss_k1", ss_a, 0);
        n = 1;
        while (!dv_a && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("t1_dv_time", n, 201);
        chk("t1_data", data_a, 16'hA55A);
        chk("t1_ss_pub", ss_a, 1);
        @(negedge clk);
        chk("t1_dv_width", dv_a, 0);
        n = 0;
        while (busy_a && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t1_busy_drop", busy_a, 0);
        repeat (2) @(negedge clk);
        chk("t1_ss_len", ss_last, 200);
        chk("t1_busy_len", busy_last, 204);
        chk("t2_rises", rises, 24);
        chk("t2_mosi", mosi_sh, 24'hBBFFFF);
        chk("t2_period", per_bad, 0);
        chk("t2_mosi_stable", mosi_bad, 0);
        chk("t2_sck_idle", sck_bad, 0);
        chk("t1_dv_count", dv_tot - dv0, 1);

        // Overrun: trigger held for 150 cycles from cycle 50 of a burst.
        slv_a = 16'h1122;
        dv0 = dv_tot;
        pulse_a();
        repeat (50) @(negedge clk);
        trigger = 1'b1;
        repeat (100) @(negedge clk);
        chk("t3_data_hold", data_a, 16'hA55A);
        chk("t3_ovr_mid", ovr_a, 100);
        repeat (50) @(negedge clk);
        trigger = 1'b0;
        wait_dv_a("t3_dv", n);
        chk("t3_data", data_a, 16'h1122);
        chk("t3_ovr", ovr_a, 150);
        repeat (30) @(negedge clk);
        chk("t3_idle", busy_a, 0);
        chk("t3_no_extra", dv_tot - dv0, 1);

        // Disabled: trigger ignored entirely.
        en = 1'b0;
        pulse_a();
        repeat (10) @(negedge clk);
        chk("t4_busy", busy_a, 0);
        chk("t4_ss", ss_a, 1);
        chk("t4_ovr", ovr_a, 150);
        en = 1'b1;

        // Second overrun burst saturates; en drops mid-burst and the burst still completes.
        slv_a = 16'h33C4;
        pulse_a();
        repeat (50) @(negedge clk);
        trigger = 1'b1;
        repeat (150) @(negedge clk);
        trigger = 1'b0;
        en = 1'b0;
        wait_dv_a("t3b_dv", n);
        chk("t3b_data", data_a, 16'h33C4);
        chk("t3b_ovr_sat", ovr_a, 255);
        en = 1'b1;
        repeat (20) @(negedge clk);

        // Reset mid-burst while SCK is high.
        slv_a = 16'hDEAD;
        dv0 = dv_tot;
        pulse_a();
        repeat (121) @(negedge clk);
        chk("t5_sck_pre", sck_a, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_ss", ss_a, 1);
        chk("t5_sck", sck_a, 0);
        chk("t5_busy", busy_a, 0);
        chk("t5_data", data_a, 0);
        chk("t5_ovr", ovr_a, 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("t5_no_dv", dv_tot - dv0, 0);
        chk("t5_data_post", data_a, 0);
        slv_a = 16'hC33C;
        pulse_a();
        wait_dv_a("t5_dv", n);
        chk("t5_clean_data", data_a, 16'hC33C);
        repeat (20) @(negedge clk);
        chk("t5_ss_len", ss_last, 200);
        chk("t5_rises", rises, 24);

        // 14-byte instance, periodic triggers.
        en_b = 1'b1;
        for (int b = 0; b < 2; b++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom};
            slv_b = rnd[111:0];
            @(negedge clk) trigger_b = 1'b1;
            @(negedge clk) trigger_b = 1'b0;
            got = 0;
            for (int c = 0; c < 9000; c++) begin
                @(negedge clk);
                if (dv_b && got == 0) begin
                    got = 1;
                    chk("t6_data", data_b, slv_b);
                end
            end
            chk("t6_got_dv", got, 1);
            chk("t6_ss_len", ss_last_b, 7744);
        end
        chk("t6_ovr", ovr_b, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
